// File: rtl/risc_pkg.sv
// Shared core constants and the register index type used by decode, writeback
// and the register file.
package risc_pkg;

    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;

    typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: tracks one outstanding writer per register and
// raises stall for RAW (operand) and WAW (destination) hazards.
module wb_scoreboard
    import risc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_use,
    input  logic            rs2_use,
    output logic            stall,
    output logic [NREG-1:0] pend
);

    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] iss_set;
    logic [NREG-1:0] eff;

    always_comb begin
        wb_hit = '0;
        if (wb_en) begin
            wb_hit[wb_rd] = 1'b1;
        end
    end

    // A register written back this cycle is ready now; bypass supplies its data.
    assign eff = pend & ~wb_hit;

    assign stall = (rs1_use && eff[rs1_addr])
                || (rs2_use && eff[rs2_addr])
                || (iss_en  && eff[iss_rd]);

    always_comb begin
        iss_set = '0;
        if (iss_en && !stall) begin
            iss_set[iss_rd] = 1'b1;
        end
    end

    // Set is applied after clear: a new writer accepted in the retiring cycle stays outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~wb_hit) | iss_set;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Eight-entry register file with two bypassed combinational read ports and a
// pending-write scoreboard that stalls issue on in-flight results.
module reg_file
    import risc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [DW-1:0]   wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_use,
    input  logic            rs2_use,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic [DW-1:0]   rs1_data,
    output logic [DW-1:0]   rs2_data,
    output logic            stall,
    output logic [NREG-1:0] pend
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Writeback forwarding gives zero-cycle write-to-read latency.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (wb_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (wb_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_use  (rs1_use),
        .rs2_use  (rs2_use),
        .stall    (stall),
        .pend     (pend)
    );

endmodule
